// File: rtl/bullet_manager.sv
// Four-slot bullet pool: edge-triggered fire requests, per-frame movement,
// off-screen retirement, spawn cooldown and a restart clear.
module bullet_manager #(
    parameter int unsigned SPEED     = 8,
    parameter int unsigned COOLDOWN  = 10,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned SPAWN_OFS = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        shoot,
    input  logic        restart,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic        facing,
    output logic [3:0]  bullet_valid,
    output logic [39:0] bullet_x,
    output logic [39:0] bullet_y,
    output logic [3:0]  bullet_dir,
    output logic        fire_event,
    output logic [2:0]  active_count
);
    localparam int unsigned N  = 4;
    localparam int unsigned XW = 10;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic {FREE = 1'b0, FLY = 1'b1} slot_state_e;

    slot_state_e       state_q [N];
    slot_state_e       state_d [N];
    logic [XW-1:0]     x_q [N];
    logic [XW-1:0]     x_d [N];
    logic [XW-1:0]     y_q [N];
    logic [XW-1:0]     y_d [N];
    logic              dir_q [N];
    logic              dir_d [N];
    logic              shoot_q;
    logic              armed_q;
    logic              pending_q, pending_d;
    logic [CW-1:0]     cool_q, cool_d;
    logic              spawn_c;
    logic [2:0]        count_d;
    logic              shoot_edge_c;
    logic [XW:0]       spawn_sum;
    logic [XW:0]       mv_sum;
    logic [XW-1:0]     spawn_x;
    logic              spawn_legal;
    logic              free_found;
    logic [IW-1:0]     free_idx;

    // armed_q suppresses a false edge when reset releases with shoot already held
    assign shoot_edge_c = armed_q & shoot & ~shoot_q;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            dir_d[i]   = dir_q[i];
        end
        pending_d  = pending_q;
        cool_d     = cool_q;
        mv_sum     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        count_d    = '0;

        spawn_sum   = (XW+1)'(player_x) + (XW+1)'(SPAWN_OFS);
        spawn_legal = facing ? (spawn_sum <= (XW+1)'(X_MAX))
                             : ((XW+1)'(player_x) >= (XW+1)'(SPAWN_OFS));
        spawn_x     = facing ? spawn_sum[XW-1:0] : (player_x - XW'(SPAWN_OFS));

        // Lowest-index free slot, sampled before this tick's retirements
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        spawn_c = frame_tick & ~restart & pending_q & (cool_q == '0)
                & free_found & spawn_legal;

        if (restart) begin
            for (int i = 0; i < int'(N); i++) state_d[i] = FREE;
            pending_d = 1'b0;
            cool_d    = '0;
        end else if (frame_tick) begin
            for (int i = 0; i < int'(N); i++) begin
                if (state_q[i] == FLY) begin
                    if (dir_q[i]) begin
                        mv_sum = (XW+1)'(x_q[i]) + (XW+1)'(SPEED);
                        if (mv_sum > (XW+1)'(X_MAX)) state_d[i] = FREE;
                        else                         x_d[i] = mv_sum[XW-1:0];
                    end else begin
                        if ((XW+1)'(x_q[i]) < (XW+1)'(SPEED)) state_d[i] = FREE;
                        else                                  x_d[i] = x_q[i] - XW'(SPEED);
                    end
                end
            end
            if (spawn_c) begin
                state_d[free_idx] = FLY;
                x_d[free_idx]     = spawn_x;
                y_d[free_idx]     = player_y;
                dir_d[free_idx]   = facing;
                cool_d            = CW'(COOLDOWN);
            end else if (cool_q != '0) begin
                cool_d = cool_q - CW'(1);
            end
            // The tick consumes the old request; an edge in the same cycle is a new one
            pending_d = shoot_edge_c;
        end else begin
            pending_d = pending_q | shoot_edge_c;
        end

        for (int i = 0; i < int'(N); i++) begin
            count_d = count_d + 3'(state_d[i] == FLY);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(N); i++) begin
                state_q[i] <= FREE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                dir_q[i]   <= 1'b0;
            end
            shoot_q      <= 1'b0;
            armed_q      <= 1'b0;
            pending_q    <= 1'b0;
            cool_q       <= '0;
            fire_event   <= 1'b0;
            active_count <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                dir_q[i]   <= dir_d[i];
            end
            shoot_q      <= shoot;
            armed_q      <= 1'b1;
            pending_q    <= pending_d;
            cool_q       <= cool_d;
            fire_event   <= spawn_c;
            active_count <= count_d;
        end
    end

    always_comb begin
        bullet_valid = '0;
        bullet_x     = '0;
        bullet_y     = '0;
        bullet_dir   = '0;
        for (int i = 0; i < int'(N); i++) begin
            bullet_valid[i]      = (state_q[i] == FLY);
            bullet_x[10*i +: 10] = x_q[i];
            bullet_y[10*i +: 10] = y_q[i];
            bullet_dir[i]        = dir_q[i];
        end
    end
endmodule
